// File: rtl/vga_controller.sv
// 640x480@60 Hz VGA timing generator: divides the system clock down to a pixel
// enable and scans an 800x525 raster, producing syncs, blanking, coordinates and strobes.
module vga_controller #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned H_DISPLAY   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_DISPLAY   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic       f_tick,
    output logic [9:0] x,
    output logic [9:0] y
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d, v_q, v_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic             ptick_q, ptick_d, ftick_q, ftick_d;
    logic             tick, h_wrap, v_wrap;

    always_comb begin
        tick    = (div_q == DIV_LAST);
        h_wrap  = (h_q == H_LAST);
        v_wrap  = (v_q == V_LAST);
        div_d   = tick ? '0 : div_q + 1'b1;
        h_d     = h_q;
        v_d     = v_q;
        if (tick) begin
            h_d = h_wrap ? '0 : h_q + 1'b1;
            if (h_wrap) begin
                v_d = v_wrap ? '0 : v_q + 1'b1;
            end
        end
        // Syncs decode the next counter values so they register in step with x/y.
        hsync_d = ((h_d >= HS_FIRST) && (h_d <= HS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d = ((v_d >= VS_FIRST) && (v_d <= VS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        ptick_d = tick;
        ftick_d = tick && h_wrap && v_wrap;
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= ~SYNC_ACTIVE;
            vsync_q <= ~SYNC_ACTIVE;
            ptick_q <= 1'b0;
            ftick_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            ptick_q <= ptick_d;
            ftick_q <= ftick_d;
        end
    end

    assign video_on = (h_q < H_VIS) && (v_q < V_VIS) && !reset;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign p_tick   = ptick_q;
    assign f_tick   = ftick_q;
    assign x        = h_q;
    assign y        = v_q;

endmodule

// File: tb/tb_vga_controller.sv
// Bench for vga_controller: a default 640x480 instance and a shrunken instance,
// checked against an arithmetic raster model, directed vectors and frame statistics.
module tb_vga_controller;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       p;
        logic       f;
        logic       hs;
        logic       vs;
        logic       vo;
    } obs_t;

    typedef struct {
        longint cd, hd, hf, hs, hb, vd, vf, vs, vb;
    } cfg_t;

    typedef struct {
        longint n;
        obs_t   e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       ahs, avs, avo, ap, af, bhs, bvs, bvo, bp, bf;
    logic [9:0] ax, ay, bx, by;

    vga_controller dut_a (
        .clk_100MHz(clk), .reset(rst), .hsync(ahs), .vsync(avs), .video_on(avo),
        .p_tick(ap), .f_tick(af), .x(ax), .y(ay)
    );

    vga_controller #(
        .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_ACTIVE(1'b0)
    ) dut_b (
        .clk_100MHz(clk), .reset(rst), .hsync(bhs), .vsync(bvs), .video_on(bvo),
        .p_tick(bp), .f_tick(bf), .x(bx), .y(by)
    );

    obs_t oa, ob;
    assign oa = {ax, ay, ap, af, ahs, avs, avo};
    assign ob = {bx, by, bp, bf, bhs, bvs, bvo};

    // rising edges since reset was last released
    longint n;
    always @(posedge clk or posedge rst) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    int checks = 0;
    int passes = 0;
    cfg_t CA, CB;

    function automatic obs_t mk(int xx, int yy, bit p, bit f, bit hs, bit vs, bit vo);
        obs_t o;
        o.x = 10'(xx); o.y = 10'(yy);
        o.p = p; o.f = f; o.hs = hs; o.vs = vs; o.vo = vo;
        return o;
    endfunction

    // Pixel k = n / CLK_DIV since release; position is k folded onto the raster.
    function automatic obs_t model(cfg_t c, longint nn, bit in_rst);
        longint ht, vt, k, xx, yy;
        bit p, f, hact, vact;
        if (in_rst) return mk(0, 0, 0, 0, 1, 1, 0);
        ht   = c.hd + c.hf + c.hs + c.hb;
        vt   = c.vd + c.vf + c.vs + c.vb;
        k    = nn / c.cd;
        xx   = k % ht;
        yy   = (k / ht) % vt;
        p    = (nn > 0) && (nn % c.cd == 0);
        f    = p && (k % (ht * vt) == 0);
        hact = (xx >= c.hd + c.hf) && (xx < c.hd + c.hf + c.hs);
        vact = (yy >= c.vd + c.vf) && (yy < c.vd + c.vf + c.vs);
        return mk(int'(xx), int'(yy), p, f, !hact, !vact, (xx < c.hd) && (yy < c.vd));
    endfunction

    task automatic cmp(input string nm, input obs_t got, input obs_t exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s t=%0t n=%0d got x=%0d y=%0d p=%b f=%b hs=%b vs=%b vo=%b required x=%0d y=%0d p=%b f=%b hs=%b vs=%b vo=%b",
                      nm, $time, n, got.x, got.y, got.p, got.f, got.hs, got.vs, got.vo,
                      exp.x, exp.y, exp.p, exp.f, exp.hs, exp.vs, exp.vo);
    endtask

    task automatic cmp_int(input string nm, input longint got, input longint exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s got %0d required %0d", nm, got, exp);
    endtask

    task automatic run_cmp(input int cyc);
        repeat (cyc) begin
            @(negedge clk);
            cmp("model_a", oa, model(CA, n, rst));
            cmp("model_b", ob, model(CB, n, rst));
        end
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        rst = 1'b1;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vecs[$];
    longint cur;
    longint cnt_hs, cnt_vo, cnt_vs, cnt_cyc, first_hs, last_hs;
    bit found;

    initial begin
        CA = '{4, 640, 16, 96, 48, 480, 10, 2, 33};
        CB = '{2, 8, 2, 2, 2, 4, 1, 1, 1};

        // reset held: reset values, video_on low
        repeat (4) begin
            @(negedge clk);
            cmp("rst_hold_a", oa, mk(0, 0, 0, 0, 1, 1, 0));
            cmp("rst_hold_b", ob, mk(0, 0, 0, 0, 1, 1, 0));
        end

        // directed vectors for the default instance, indexed by edges since release
        vecs.push_back('{1,    mk(0,   0, 0, 0, 1, 1, 1)});
        vecs.push_back('{3,    mk(0,   0, 0, 0, 1, 1, 1)});
        vecs.push_back('{4,    mk(1,   0, 1, 0, 1, 1, 1)});
        vecs.push_back('{5,    mk(1,   0, 0, 0, 1, 1, 1)});
        vecs.push_back('{8,    mk(2,   0, 1, 0, 1, 1, 1)});
        vecs.push_back('{2556, mk(639, 0, 1, 0, 1, 1, 1)});
        vecs.push_back('{2560, mk(640, 0, 1, 0, 1, 1, 0)});
        vecs.push_back('{2623, mk(655, 0, 0, 0, 1, 1, 0)});
        vecs.push_back('{2624, mk(656, 0, 1, 0, 0, 1, 0)});
        vecs.push_back('{3004, mk(751, 0, 1, 0, 0, 1, 0)});
        vecs.push_back('{3008, mk(752, 0, 1, 0, 1, 1, 0)});
        vecs.push_back('{3196, mk(799, 0, 1, 0, 1, 1, 0)});
        vecs.push_back('{3200, mk(0,   1, 1, 0, 1, 1, 1)});
        vecs.push_back('{3201, mk(0,   1, 0, 0, 1, 1, 1)});
        @(negedge clk);
        rst = 1'b0;
        cur = 0;
        foreach (vecs[i]) begin
            repeat (int'(vecs[i].n - cur)) @(posedge clk);
            @(negedge clk);
            cur = vecs[i].n;
            cmp($sformatf("vec_a_n%0d", vecs[i].n), oa, vecs[i].e);
        end

        // one full line of the default instance: hsync window and visible ticks
        do_reset(2);
        cnt_hs = 0; cnt_vo = 0; first_hs = -1; last_hs = -1;
        repeat (3200) begin
            @(negedge clk);
            cmp("line_a", oa, model(CA, n, rst));
            if (ap) begin
                if (!ahs) begin
                    cnt_hs++;
                    if (first_hs < 0) first_hs = ax;
                    last_hs = ax;
                end
                if (avo) cnt_vo++;
            end
        end
        cmp_int("line_hsync_ticks", cnt_hs, 96);
        cmp_int("line_hsync_first_x", first_hs, 656);
        cmp_int("line_hsync_last_x", last_hs, 751);
        cmp_int("line_video_ticks", cnt_vo, 640);

        // small instance: f_tick spacing and per-frame statistics
        do_reset(1);
        found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            cmp("pre_frame_b", ob, model(CB, n, rst));
            found = bf;
        end
        cmp_int("frame_b_first_ftick_seen", found, 1);
        cmp_int("frame_b_ftick_at_origin", {bx, by}, 0);
        cnt_cyc = 0; cnt_hs = 0; cnt_vs = 0; cnt_vo = 0; found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            cmp("frame_b", ob, model(CB, n, rst));
            cnt_cyc++;
            if (bp) begin
                if (!bhs) cnt_hs++;
                if (!bvs) cnt_vs++;
                if (bvo) cnt_vo++;
            end
            found = bf;
        end
        cmp_int("frame_b_clks", cnt_cyc, 196);
        cmp_int("frame_b_hsync_ticks", cnt_hs, 14);
        cmp_int("frame_b_vsync_ticks", cnt_vs, 14);
        cmp_int("frame_b_video_ticks", cnt_vo, 32);

        // reset inside both sync pulses of the small instance
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            found = (bx == 10) && (by == 5);
        end
        cmp_int("mid_b_reached", found, 1);
        cmp_int("mid_b_syncs_active", {bhs, bvs}, 0);
        #2 rst = 1'b1;
        #1 cmp("mid_b_async", ob, mk(0, 0, 0, 0, 1, 1, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cmp("mid_b_release", ob, mk(0, 0, 0, 0, 1, 1, 1));
        run_cmp(30);

        // randomized run lengths with asynchronous resets in between
        for (int it = 0; it < 25; it++) begin
            run_cmp($urandom_range(1, 700));
            @(negedge clk);
            #2 rst = 1'b1;
            #1;
            cmp("rand_rst_a", oa, model(CA, n, 1'b1));
            cmp("rand_rst_b", ob, model(CB, n, 1'b1));
            repeat ($urandom_range(1, 3)) @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
        end
        run_cmp(100);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/vga_controller.md
Name: vga_controller

Overview:
- Timing generator for the VGA display path; sits directly upstream of the pixel colour generator.
- Divides the 100 MHz system clock down to a 25 MHz pixel enable.
- Runs horizontal and vertical pixel counters over the full 800x525 raster of 640x480@60 Hz.
- Produces hsync, vsync, video_on and the current pixel coordinates x, y consumed by the colour stage, plus pixel-tick and frame-start strobes.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz)
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, logic level of hsync/vsync during the sync pulse

Ports:
- clk_100MHz  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- hsync  output  1  horizontal sync to connector
- vsync  output  1  vertical sync to connector
- video_on  output  1  high while (x,y) is inside the visible area
- p_tick  output  1  one-clk pulse per pixel period
- f_tick  output  1  one-clk pulse at start of each frame
- x  output  10  current horizontal count, 0..H_TOTAL-1
- y  output  10  current vertical count, 0..V_TOTAL-1

Behaviour:
- Clocking and reset: one clock (clk_100MHz); reset is asynchronous and active-high. All state is reset asynchronously.
- Derived totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK = 800; V_TOTAL = 480+10+2+33 = 525.
- Reset values: divider 0, h_count 0, v_count 0, p_tick 0, f_tick 0, hsync = vsync = ~SYNC_ACTIVE.
- video_on is 0 for as long as reset is asserted.
- Pixel divider: counter runs 0..CLK_DIV-1 and wraps. p_tick is registered and high for exactly one clk when the divider equals CLK_DIV-1, giving 1 pulse per 4 clks. The first p_tick occurs on the 4th rising edge after reset deasserts.
- Horizontal counter: on each p_tick, h_count increments. At H_TOTAL-1 it wraps to 0. It holds between ticks.
- Vertical counter: increments only on a p_tick where h_count wraps. At V_TOTAL-1 (on that same wrap) it goes to 0.
- x = h_count, y = v_count, both driven directly from the registers.
- hsync/vsync: registered from the next-state counter values, so they stay aligned with x/y (zero relative latency).
  - hsync = SYNC_ACTIVE when H_DISPLAY+H_FRONT <= h_count <= H_DISPLAY+H_FRONT+H_SYNC-1, i.e. 656..751.
  - vsync = SYNC_ACTIVE when v_count is 490..491.
- video_on = (h_count < H_DISPLAY) && (v_count < V_DISPLAY) && !reset. It is combinational from the registered counters only.
- f_tick: registered; high for one clk on the p_tick that moves the counters from (799,524) to (0,0).
- Width rules: counters are 10 bits. Comparisons are unsigned. Counters never exceed H_TOTAL-1 / V_TOTAL-1.
- Reset mid-frame: the counters, divider and syncs return to their reset values immediately (asynchronously). Scanning restarts at (0,0) and no partial sync pulse continues. f_tick is not asserted for the restart after reset.
- No handshake with the downstream stage: the consumer samples x, y and video_on whenever it likes. Values are stable for CLK_DIV clks between p_ticks.

Test Plan:
- Reset held, then released -> all outputs at reset values while held; first p_tick on the 4th clk after release; p_tick period exactly 4 clks thereafter.
- Run 1 line -> x counts 0..799 then 0; y increments 0->1 on the wrap; hsync = SYNC_ACTIVE for exactly 96 p_ticks, starting at x=656 and ending after x=751.
- Run 1 full frame -> exactly 1,680,000 clks between f_ticks; vsync active only on y=490 and y=491 (1600 p_ticks); y wraps 524->0 together with x 799->0.
- Count video_on-high p_ticks over a frame -> exactly 307,200; video_on low at x=640 (any y<480) and at y=480 (any x).
- Assert reset at x=700, y=491 (mid-hsync, mid-vsync) -> hsync and vsync go inactive immediately; after release x=y=0, video_on=1, no f_tick.
- Override parameters (CLK_DIV=2, H_DISPLAY=8, H_FRONT=2, H_SYNC=2, H_BACK=2, V_DISPLAY=4, V_FRONT/V_SYNC/V_BACK=1) -> line of 14 ticks, frame of 7 lines, hsync at x=10..11, vsync at y=5.
